// File: rtl/mod_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, state codes,
// datapath select codes and the packed control word.
package mod_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    pc_source_e pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    logic       insn_done;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mod_ctrl_out_decode.sv
// Moore output decode: maps the current state (and mem_ready in the two
// handshake states that complete on it) to the full datapath control word.
module mod_ctrl_out_decode
  import mod_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    // NOTE: default the whole word first so every path assigns every bit; a
    // missing assignment in any branch would otherwise infer a latch.
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.insn_done  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.insn_done = mem_ready_i;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.insn_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.insn_done     = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.insn_done = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.insn_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mod_multicycle_ctrl.sv
// Multicycle MIPS control unit: state register, next-state logic and the
// registered illegal-opcode pulse; outputs come from mod_ctrl_out_decode.
module mod_multicycle_ctrl
  import mod_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       insn_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl_raw, ctrl;

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
        illegal_d = !is_known_op(opcode);
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_READ;
        else if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  mod_ctrl_out_decode u_out_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_raw)
  );

  // Reset overrides the FETCH strobes combinationally so nothing fires while held.
  assign ctrl = rst ? '0 : ctrl_raw;

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign insn_done     = ctrl.insn_done;
  assign illegal_op    = illegal_q;
  assign state         = state_q;

endmodule

// File: tb/tb_mod_multicycle_ctrl.sv
// Self-checking bench: random instruction stream with random memory stalls,
// compared cycle by cycle against an instruction-level reference model.
module tb_mod_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, insn_done, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  logic ill_pending = 1'b0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc;
    logic [1:0] pcs;
    logic       iord, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop;
    logic       done, ill;
  } obs_t;

  mod_multicycle_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .insn_done     (insn_done),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '{st: state, pcw: pc_write, pcwc: pc_write_cond, pcs: pc_source,
          iord: i_or_d, mr: mem_read, mw: mem_write, irw: ir_write,
          m2r: mem_to_reg, rd: reg_dst, rw: reg_write, asa: alu_src_a,
          asb: alu_src_b, aop: alu_op, done: insn_done, ill: illegal_op};
    return o;
  endfunction

  // One clock cycle: drive mem_ready, compare mid-cycle, advance past the edge.
  task automatic step(input logic rdy, input obs_t e, input string tag);
    mem_ready = rdy;
    e.ill = ill_pending;
    ill_pending = 1'b0;
    @(negedge clk);
    check(tag, {10'b0, sample()}, {10'b0, e});
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level model: the expected cycle sequence for one instruction.
  task automatic run_insn(input logic [5:0] op, input int wf, input int wm, input bit abort_wb);
    obs_t e;
    opcode = op;
    for (int i = 0; i < wf; i++) begin
      e = '0; e.st = 4'd0; e.mr = 1'b1; e.asb = 2'b01;
      step(1'b0, e, "fetch_wait");
    end
    e = '0; e.st = 4'd0; e.mr = 1'b1; e.asb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
    step(1'b1, e, "fetch");
    e = '0; e.st = 4'd1; e.asb = 2'b11;
    step(rnd_bit(), e, "decode");
    case (op)
      6'b000000: begin
        e = '0; e.st = 4'd6; e.asa = 1'b1; e.aop = 2'b10;
        step(rnd_bit(), e, "r_exec");
        e = '0; e.st = 4'd7; e.rd = 1'b1; e.rw = 1'b1; e.done = 1'b1;
        step(rnd_bit(), e, "r_wb");
      end
      6'b100011, 6'b101011: begin
        e = '0; e.st = 4'd2; e.asa = 1'b1; e.asb = 2'b10;
        step(rnd_bit(), e, "mem_addr");
        if (op == 6'b100011) begin
          for (int i = 0; i <= wm; i++) begin
            e = '0; e.st = 4'd3; e.mr = 1'b1; e.iord = 1'b1;
            step(i == wm, e, "lw_read");
          end
          e = '0; e.st = 4'd4; e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
          if (!abort_wb) begin
            step(rnd_bit(), e, "lw_wb");
          end else begin
            mem_ready = 1'b1;
            @(negedge clk);
            check("lw_wb_pre_rst", {10'b0, sample()}, {10'b0, e});
            #2 rst = 1'b1;
            #1 check("rst_mid_wb", {10'b0, sample()}, 32'd0);
            check("rst_reg_write", {31'b0, reg_write}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_hold", {10'b0, sample()}, 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            e = '0; e.mr = 1'b1; e.asb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
            check("post_rst_fetch", {10'b0, sample()}, {10'b0, e});
          end
        end else begin
          for (int i = 0; i <= wm; i++) begin
            e = '0; e.st = 4'd5; e.mw = 1'b1; e.iord = 1'b1; e.done = (i == wm);
            step(i == wm, e, "sw_write");
          end
        end
      end
      6'b000100: begin
        e = '0; e.st = 4'd8; e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1;
        e.pcs = 2'b01; e.done = 1'b1;
        step(rnd_bit(), e, "beq");
      end
      6'b000010: begin
        e = '0; e.st = 4'd9; e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1;
        step(rnd_bit(), e, "jump");
      end
      6'b001000: begin
        e = '0; e.st = 4'd10; e.asa = 1'b1; e.asb = 2'b10;
        step(rnd_bit(), e, "addi_ex");
        e = '0; e.st = 4'd11; e.rw = 1'b1; e.done = 1'b1;
        step(rnd_bit(), e, "addi_wb");
      end
      default: ill_pending = 1'b1;
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    logic [5:0] op;
    if ($urandom_range(0, 6) != 0) return legal[$urandom_range(0, 5)];
    do op = 6'($urandom_range(0, 63));
    while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
    return op;
  endfunction

  function automatic int pick_wait();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
  endfunction

  initial begin
    rst = 1'b1;
    opcode = 6'd0;
    mem_ready = 1'b0;
    #3;
    check("reset_rdy0", {10'b0, sample()}, 32'd0);
    mem_ready = 1'b1;
    #1 check("reset_rdy1", {10'b0, sample()}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_insn(6'b000000, 0, 0, 1'b0);
    run_insn(6'b100011, 0, 2, 1'b0);
    run_insn(6'b001000, 0, 0, 1'b0);
    run_insn(6'b101011, 0, 0, 1'b0);
    run_insn(6'b000100, 0, 0, 1'b0);
    run_insn(6'b000010, 0, 0, 1'b0);
    run_insn(6'b111111, 0, 0, 1'b0);
    run_insn(6'b000000, 1, 0, 1'b0);
    run_insn(6'b101011, 2, 3, 1'b0);
    run_insn(6'b100011, 0, 0, 1'b1);

    for (int n = 0; n < 80; n++)
      run_insn(pick_op(), pick_wait(), pick_wait(), 1'b0);
    run_insn(6'b000000, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
